// File: rtl/sensor_preproc_scheduler.sv
// Round-robin scheduler sharing one combinational clipping preprocessor among N_REQ sensors.
// Define SENSOR_PREPROC_FAULT_CNT_EN to build the per-requester saturating fault counters.
module sensor_preproc_scheduler #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         in_valid,
  output logic [N_REQ-1:0]         in_ready,
  input  logic [N_REQ*256-1:0]     in_vector,
  output logic [255:0]             pp_raw_vector,
  input  logic [255:0]             pp_normalized_vector,
  input  logic [15:0]              pp_error_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [255:0]             out_vector,
  output logic [15:0]              out_error_flags,
  output logic [IDX_W-1:0]         out_src,
  input  logic                     cnt_clr,
  output logic [N_REQ*CNT_W-1:0]   fault_counts
);

  // state     | meaning
  // ST_IDLE   | offering a grant to the next valid requester after r_rr_ptr
  // ST_ISSUE  | held vector drives the preprocessor; result captured at the edge
  // ST_OUTPUT | result held until downstream accepts
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_OUTPUT} state_t;

  localparam logic [IDX_W:0]   N_REQ_W  = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_src;
  logic [255:0]     r_vec;
  logic             r_out_valid;
  logic [255:0]     r_out_vec;
  logic [15:0]      r_out_flags;
  logic [IDX_W-1:0] r_out_src;

  logic [255:0]     w_slice [N_REQ];
  logic             w_gnt_vld;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [IDX_W-1:0] w_nxt_ptr;
  logic [IDX_W:0]   w_cand;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_slice[i] = in_vector[256*i +: 256];
    end
  end

  // Scan from the farthest candidate back to r_rr_ptr so the nearest valid one wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_cand >= N_REQ_W) begin
        w_cand = w_cand - N_REQ_W;
      end
      if (in_valid[w_cand[IDX_W-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_nxt_ptr = (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + 1'b1;

  // Gated by rst_n so no requester sees an accept while reset is held.
  always_comb begin
    in_ready = '0;
    if (rst_n && r_state == ST_IDLE && w_gnt_vld) begin
      in_ready[w_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_src       <= '0;
      r_vec       <= '0;
      r_out_valid <= 1'b0;
      r_out_vec   <= '0;
      r_out_flags <= '0;
      r_out_src   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_vec    <= w_slice[w_gnt_idx];
            r_src    <= w_gnt_idx;
            r_rr_ptr <= w_nxt_ptr;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_out_vec   <= pp_normalized_vector;
          r_out_flags <= pp_error_flags;
          r_out_src   <= r_src;
          r_out_valid <= 1'b1;
          r_state     <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pp_raw_vector   = r_vec;
  assign out_valid       = r_out_valid;
  assign out_vector      = r_out_vec;
  assign out_error_flags = r_out_flags;
  assign out_src         = r_out_src;

`ifdef SENSOR_PREPROC_FAULT_CNT_EN
  logic [CNT_W-1:0] r_cnt [N_REQ];

  // Clear wins over a same-edge increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
    end else if (r_state == ST_ISSUE && (|pp_error_flags) &&
                 r_cnt[r_src] != {CNT_W{1'b1}}) begin
      r_cnt[r_src] <= r_cnt[r_src] + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      fault_counts[CNT_W*i +: CNT_W] = r_cnt[i];
    end
  end
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign fault_counts     = '0;
`endif

endmodule

// File: doc/sensor_preproc_scheduler.md
Name: sensor_preproc_scheduler

Overview:
- Round-robin scheduler sharing one combinational 16-lane clipping preprocessor among N_REQ sensor front-ends (camera, LiDAR, radar, IMU).
- Accepts a 256-bit raw vector from one requester at a time and drives it to the shared preprocessor.
- Captures the normalized vector and 16-bit error flags, then returns them tagged with the source index.
- Keeps per-sensor fault statistics for the Fault Monitor.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of source index; must equal ceil(log2(N_REQ)).
- CNT_W, 16, width of each per-requester fault counter.

Ports:
- clk  in  1  single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  N_REQ  per-requester vector valid.
- in_ready  out  N_REQ  per-requester accept; at most one bit set.
- in_vector  in  N_REQ*256  requester i occupies bits [256*i+255:256*i].
- pp_raw_vector  out  256  to shared preprocessor raw input.
- pp_normalized_vector  in  256  from shared preprocessor.
- pp_error_flags  in  16  from shared preprocessor; one bit per lane.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_vector  out  256  clipped vector.
- out_error_flags  out  16  captured flags.
- out_src  out  IDX_W  index of the originating requester.
- cnt_clr  in  1  synchronous clear of all fault counters.
- fault_counts  out  N_REQ*CNT_W  per-requester fault counters.

Behaviour:
- Reset (async assert, sync deassert by the integrator) forces the following:
  - state = IDLE; rr_ptr = 0.
  - in_ready = 0; out_valid = 0.
  - out_vector, out_error_flags, out_src, pp_raw_vector = 0.
  - all fault_counts = 0.
- Reset mid-operation drops any held vector or result without emitting it.
- FSM has three states: IDLE -> ISSUE -> OUTPUT -> IDLE.
- IDLE:
  - grant = first index g at or after rr_ptr (wrapping modulo N_REQ) with in_valid[g] = 1.
  - in_ready[g] = 1 combinationally; all other in_ready bits = 0.
  - No in_valid set: no grant; stay in IDLE.
  - On handshake: latch in_vector slice g into vec_reg and g into src_reg; rr_ptr <= (g+1) mod N_REQ; go to ISSUE.
- ISSUE (one cycle):
  - pp_raw_vector = vec_reg. It is a registered output, stable the whole cycle.
  - At the clock edge: out_vector <= pp_normalized_vector, out_error_flags <= pp_error_flags, out_src <= src_reg, out_valid <= 1; go to OUTPUT.
- OUTPUT:
  - out_valid, out_vector, out_error_flags and out_src hold stable until out_ready = 1.
  - On handshake: out_valid <= 0; go to IDLE.
  - No new grant is issued in the handshake cycle.
- Latency and throughput:
  - Input handshake at cycle T gives out_valid = 1 at T+2.
  - With out_ready held high, throughput is 1 vector per 3 cycles.
- Requester rules:
  - in_valid must stay high with in_vector stable until in_ready.
  - in_ready is never asserted outside IDLE.
- Fairness: a continuously requesting sensor waits at most N_REQ-1 grants.
- Fault counting at the ISSUE edge: if |pp_error_flags != 0, fault_counts[src_reg] increments by 1.
  - The counter saturates at 2^CNT_W-1; no wrap.
- cnt_clr:
  - Zeroes all counters on the next edge.
  - Has priority over a same-cycle increment; that increment is lost.
- pp_raw_vector keeps its last value outside ISSUE; no toggling to 0.

Optional Feature:
- Macro: SENSOR_PREPROC_FAULT_CNT_EN.
- Defined: fault counters, the saturation rule and cnt_clr behave as above.
- Undefined: no counter registers are synthesized, fault_counts is tied to 0 and cnt_clr is ignored. All other behaviour is unchanged.

Test Plan:
- Single request: requester 2 sends all lanes 0x7FFF, out_ready = 1.
  - Expect in_ready[2] at T, out_valid at T+2.
  - Expect all lanes 0x3FFF, out_error_flags = 0xFFFF, out_src = 2, fault_counts[2] = 1.
- In-range pass-through: lanes 0xC000, 0x0000, 0x3FFF alternating.
  - Expect the vector unchanged, flags = 0x0000 and no counter change.
- Round-robin: all four in_valid held high with out_ready = 1.
  - Expect out_src sequence 0,1,2,3,0, each result 3 cycles apart, never two bits of in_ready set.
- Backpressure: out_ready = 0 for 10 cycles after out_valid.
  - Expect outputs stable, in_ready = 0 throughout, and release 1 cycle after out_ready = 1.
- Saturation and clear, with CNT_W = 4 via override:
  - Send 20 faulty vectors from requester 1; expect count 15.
  - Pulse cnt_clr in the same cycle as a faulty capture; expect count 0 afterwards.
- Reset mid-OUTPUT: assert rst_n = 0 asynchronously while out_valid = 1.
  - Expect out_valid = 0 immediately and rr_ptr = 0.
  - After release, the first grant goes to requester 0 when all are requesting.
